duc_drive_ctl: RTL and testbench
================================

# duc_drive_ctl

Drive sequencer for the digital up-converter on the zest_soc board. It generates the slew-limited `drive_i`/`drive_q` baseband setpoints that feed the DUC, and sequences RF-on / RF-off ramps with an interlock trip. It also owns the free-running 2-bit `div_state` counter that selects the f/4 LO quadrant in the DUC.

## Interface
- `DW`, 17: drive word width (signed); matches DUC `DW`.
- `SW`, 12: slew step width (unsigned).
- `adc_clk`  in  1  sole clock; DUC adc_clk domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level; request RF on.
- `trip`  in  1  level; interlock, highest priority.
- `trip_clear`  in  1  single-cycle pulse; leave FAULT.
- `set_stb`  in  1  single-cycle pulse; latch `set_i`/`set_q`.
- `set_i`, `set_q`  in  DW  signed staged setpoint.
- `step`  in  SW  unsigned max change per cycle, per component.
- `div_sync`  in  1  pulse; realign `div_state`.
- `drive_i`, `drive_q`  out  DW  signed drive to DUC.
- `div_state`  out  2  LO quadrant select to DUC.
- `state`  out  3  FSM state code.
- `at_target`  out  1  drive equals active target.
- `tripped`  out  1  sticky fault flag.

## Operation
- Registers `tgt_i`/`tgt_q` load `set_i`/`set_q` on `set_stb` in any state, including FAULT. The new value is used from the next cycle.
- The active target is (`tgt_i`,`tgt_q`) in RAMP and ON. It is (0,0) in IDLE, DOWN and FAULT.
- Slew is applied per component, each cycle, in RAMP, ON and DOWN:
  - `d = target - drive` is computed in DW+1 bits.
  - If `|d| <= step`, drive takes the target value.
  - Otherwise drive moves by `step` toward the target, with sign taken from `d`.
  - No overflow is possible, because the result always lies between drive and target.
- `step = 0` freezes drive; the FSM holds in its current state.
- FSM states:
  - IDLE (0): drive = 0. `enable` = 1 → RAMP.
  - RAMP (1): slew toward the target. `enable` = 0 → DOWN. Both components equal to target → ON.
  - ON (2): keep slewing toward the target, so setpoint changes are slew-limited. `enable` = 0 → DOWN.
  - DOWN (3): slew toward 0. `enable` = 1 → RAMP. Both components 0 → IDLE.
  - FAULT (4): drive is forced to 0 with no slew. Exit to IDLE only when `trip_clear` = 1, `trip` = 0 and `enable` = 0 in the same cycle. Otherwise stay in FAULT.
- `trip` = 1 in any state → FAULT and `tripped` ← 1. This overrides all other transitions in the same cycle.
- `tripped` clears only on the FAULT→IDLE exit.
- `at_target` = (`drive_i`,`drive_q`) == active target, registered. It is 1 in IDLE and 0 in FAULT.
- `div_state` increments by 1 mod 4 every cycle. `div_sync` makes `div_state` = 0 on the next cycle, then counting resumes (0, 1, 2, …). `div_state` is independent of the FSM and of `trip`.

## Timing
- Reset values: `drive_i` = `drive_q` = 0, `div_state` = 0, `state` = IDLE, `at_target` = 1, `tripped` = 0, `tgt_i` = `tgt_q` = 0.
- All outputs are registered. An input sampled at edge n affects the outputs after edge n.
- `enable` rising at edge n gives `state` = RAMP after n, and the first drive step after n+1.
- `trip` at edge n gives `state` = FAULT and drive = 0 after n (one-cycle trip latency).
- The RAMP→ON transition and the final drive step happen on the same edge. `at_target` rises on that edge.
- A ramp from 0 to target T takes `ceil(max(|T_i|,|T_q|)/step)` cycles in RAMP.
- `set_stb` coinciding with any transition: the target is latched, and the transition decision uses the old target.
- `rst_n` asserted mid-ramp: all outputs go to reset values immediately (asynchronous). They are released on the first `adc_clk` edge after deassertion.

## Test plan
- Ramp up: `set_i` = 1000, `set_q` = -500, `step` = 100, `enable` = 1.
  - `drive_i` steps 0, 100, …, 1000 over 10 cycles; `drive_q` reaches -500 after 5 cycles and holds.
  - ON and `at_target` assert on cycle 10.
- Ramp down: from ON, drop `enable`.
  - DOWN, drive slews by 100 per cycle to 0, then IDLE.
  - Re-raise `enable` mid-ramp at `drive_i` = 400: RAMP resumes upward from 400.
- Setpoint change in ON: `set_stb` with `set_i` = -65536 at `step` = 4095 from `drive_i` = 65535.
  - Slews negative without wrap; reaches -65536 after 33 steps.
- Trip during RAMP at `drive_i` = 300: next cycle drive = 0, FAULT, `tripped` = 1.
  - `trip_clear` with `trip` still 1: stays in FAULT.
  - `trip_clear` with `trip` = 0 and `enable` = 0: IDLE, `tripped` = 0.
- `step` = 0 in RAMP: drive and `state` frozen for 20 cycles; `step` = 50 resumes the ramp.
- `div_state`: free-runs 0, 1, 2, 3, 0 from reset.
  - `div_sync` while `div_state` = 2 gives 0 next, then 1.
  - `div_state` is unaffected by `trip` and by `rst_n` release timing other than starting at 0.

Source files
------------

// File: rtl/duc_drive_ctl_if.sv
// Setpoint bus into the drive sequencer and the
// baseband drive / LO quadrant bundle out to the DUC.
interface duc_drive_ctl_if #(
    parameter int DW = 17,
    parameter int SW = 12
);
    logic                 set_stb;
    logic signed [DW-1:0] set_i;
    logic signed [DW-1:0] set_q;
    logic [SW-1:0]        step;
    logic signed [DW-1:0] drive_i;
    logic signed [DW-1:0] drive_q;
    logic [1:0]           div_state;

    modport master (
        output set_stb,
        output set_i,
        output set_q,
        output step,
        input  drive_i,
        input  drive_q,
        input  div_state
    );

    modport slave (
        input  set_stb,
        input  set_i,
        input  set_q,
        input  step,
        output drive_i,
        output drive_q,
        output div_state
    );
endinterface

// File: rtl/duc_drive_ctl.sv
// DUC drive sequencer: slew-limited I/Q setpoints,
// RF on/off ramps, interlock trip and f/4 LO counter.
module duc_drive_ctl #(
    parameter int DW = 17,
    parameter int SW = 12
) (
    input  logic           adc_clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic           trip,
    input  logic           trip_clear,
    input  logic           div_sync,
    duc_drive_ctl_if.slave bus,
    output logic [2:0]     state,
    output logic           at_target,
    output logic           tripped
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RAMP  = 3'd1,
        S_ON    = 3'd2,
        S_DOWN  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t               st;
    state_t               st_n;
    logic signed [DW-1:0] tgt_i;
    logic signed [DW-1:0] tgt_q;
    logic signed [DW-1:0] tgt_i_n;
    logic signed [DW-1:0] tgt_q_n;
    logic signed [DW-1:0] act_i;
    logic signed [DW-1:0] act_q;
    logic signed [DW-1:0] act_i_n;
    logic signed [DW-1:0] act_q_n;
    logic signed [DW-1:0] sl_i;
    logic signed [DW-1:0] sl_q;
    logic signed [DW-1:0] di_n;
    logic signed [DW-1:0] dq_n;
    logic                 trp_n;
    logic                 at_n;
    logic                 moving;

    // The result always lies between cur and tgt, so the
    // DW-bit add/subtract below cannot wrap.
    function automatic logic signed [DW-1:0] slew(
        input logic signed [DW-1:0] cur,
        input logic signed [DW-1:0] tgt,
        input logic [SW-1:0]        stp
    );
        logic signed [DW:0] d;
        logic [DW:0]        mag;
        d   = {tgt[DW-1], tgt} - {cur[DW-1], cur};
        mag = d[DW] ? -d : d;
        if (mag <= (DW+1)'(stp))
            return tgt;
        else if (d[DW])
            return cur - DW'(stp);
        else
            return cur + DW'(stp);
    endfunction

    assign state  = st;
    assign moving = (bus.step != '0);

    always_comb begin
        tgt_i_n = bus.set_stb ? bus.set_i : tgt_i;
        tgt_q_n = bus.set_stb ? bus.set_q : tgt_q;
        act_i   = '0;
        act_q   = '0;
        if (st == S_RAMP || st == S_ON) begin
            act_i = tgt_i;
            act_q = tgt_q;
        end
        sl_i  = slew(bus.drive_i, act_i, bus.step);
        sl_q  = slew(bus.drive_q, act_q, bus.step);
        st_n  = st;
        di_n  = bus.drive_i;
        dq_n  = bus.drive_q;
        trp_n = tripped;
        if (trip) begin
            st_n  = S_FAULT;
            di_n  = '0;
            dq_n  = '0;
            trp_n = 1'b1;
        end else begin
            unique case (st)
                S_IDLE: begin
                    di_n = '0;
                    dq_n = '0;
                    if (enable)
                        st_n = S_RAMP;
                end
                S_RAMP: begin
                    di_n = sl_i;
                    dq_n = sl_q;
                    if (moving) begin
                        if (!enable)
                            st_n = S_DOWN;
                        else if (sl_i == tgt_i &&
                                 sl_q == tgt_q)
                            st_n = S_ON;
                    end
                end
                S_ON: begin
                    di_n = sl_i;
                    dq_n = sl_q;
                    if (moving && !enable)
                        st_n = S_DOWN;
                end
                S_DOWN: begin
                    di_n = sl_i;
                    dq_n = sl_q;
                    if (moving) begin
                        if (enable)
                            st_n = S_RAMP;
                        else if (sl_i == '0 &&
                                 sl_q == '0)
                            st_n = S_IDLE;
                    end
                end
                S_FAULT: begin
                    di_n = '0;
                    dq_n = '0;
                    if (trip_clear && !enable) begin
                        st_n  = S_IDLE;
                        trp_n = 1'b0;
                    end
                end
                default: begin
                    st_n = S_IDLE;
                    di_n = '0;
                    dq_n = '0;
                end
            endcase
        end
        act_i_n = '0;
        act_q_n = '0;
        if (st_n == S_RAMP || st_n == S_ON) begin
            act_i_n = tgt_i_n;
            act_q_n = tgt_q_n;
        end
        at_n = (st_n != S_FAULT) &&
               (di_n == act_i_n) &&
               (dq_n == act_q_n);
    end

    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            st            <= S_IDLE;
            tgt_i         <= '0;
            tgt_q         <= '0;
            bus.drive_i   <= '0;
            bus.drive_q   <= '0;
            bus.div_state <= 2'd0;
            at_target     <= 1'b1;
            tripped       <= 1'b0;
        end else begin
            st            <= st_n;
            tgt_i         <= tgt_i_n;
            tgt_q         <= tgt_q_n;
            bus.drive_i   <= di_n;
            bus.drive_q   <= dq_n;
            bus.div_state <= div_sync ? 2'd0
                           : bus.div_state + 2'd1;
            at_target     <= at_n;
            tripped       <= trp_n;
        end
    end

endmodule

// File: tb/tb_duc_drive_ctl.sv
// Directed bench for duc_drive_ctl with an integer
// reference model checked on every falling edge.
module tb_duc_drive_ctl;

    logic       adc_clk;
    logic       rst_n;
    logic       enable;
    logic       trip;
    logic       trip_clear;
    logic       div_sync;
    logic [2:0] state;
    logic       at_target;
    logic       tripped;

    int total = 0;
    int bad   = 0;

    duc_drive_ctl_if #(.DW(17), .SW(12)) bus ();

    duc_drive_ctl #(.DW(17), .SW(12)) dut (
        .adc_clk    (adc_clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .trip       (trip),
        .trip_clear (trip_clear),
        .div_sync   (div_sync),
        .bus        (bus),
        .state      (state),
        .at_target  (at_target),
        .tripped    (tripped)
    );

    initial begin
        adc_clk = 1'b0;
        forever #5 adc_clk = ~adc_clk;
    end

    int m_st   = 0;
    int m_di   = 0;
    int m_dq   = 0;
    int m_ti   = 0;
    int m_tq   = 0;
    int m_div  = 0;
    bit m_trip = 1'b0;
    bit m_at   = 1'b1;

    function automatic int toward(int c, int t, int s);
        if (t - c <= s && c - t <= s)
            return t;
        return (t > c) ? c + s : c - s;
    endfunction

    function automatic int active(int s, int t);
        return (s == 1 || s == 2) ? t : 0;
    endfunction

    task automatic chk(input string nm, input int act,
                       input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int ni, nq, ns, nti, ntq, s;
        bit ntr;
        s   = int'(bus.step);
        nti = bus.set_stb ? int'(bus.set_i) : m_ti;
        ntq = bus.set_stb ? int'(bus.set_q) : m_tq;
        ni  = toward(m_di, active(m_st, m_ti), s);
        nq  = toward(m_dq, active(m_st, m_tq), s);
        ns  = m_st;
        ntr = m_trip;
        if (trip) begin
            ns = 4; ni = 0; nq = 0; ntr = 1'b1;
        end else begin
            case (m_st)
                0: if (enable) ns = 1;
                1: if (s != 0) begin
                    if (!enable) ns = 3;
                    else if (ni == m_ti && nq == m_tq)
                        ns = 2;
                end
                2: if (s != 0 && !enable) ns = 3;
                3: if (s != 0) begin
                    if (enable) ns = 1;
                    else if (ni == 0 && nq == 0) ns = 0;
                end
                default: begin
                    ni = 0; nq = 0;
                    if (trip_clear && !enable) begin
                        ns = 0; ntr = 1'b0;
                    end
                end
            endcase
        end
        m_at = (ns != 4) && ni == active(ns, nti)
               && nq == active(ns, ntq);
        m_st = ns; m_di = ni; m_dq = nq;
        m_ti = nti; m_tq = ntq; m_trip = ntr;
        m_div = div_sync ? 0 : (m_div + 1) % 4;
    endtask

    initial forever begin
        @(posedge adc_clk or negedge rst_n);
        if (!rst_n) begin
            m_st = 0; m_di = 0; m_dq = 0; m_ti = 0;
            m_tq = 0; m_div = 0; m_trip = 1'b0;
            m_at = 1'b1;
        end else begin
            model_step();
        end
    end

    always @(negedge adc_clk) begin
        chk("m_drive_i", int'(bus.drive_i), m_di);
        chk("m_drive_q", int'(bus.drive_q), m_dq);
        chk("m_state", int'(state), m_st);
        chk("m_at_target", int'(at_target), int'(m_at));
        chk("m_tripped", int'(tripped), int'(m_trip));
        chk("m_div_state", int'(bus.div_state), m_div);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge adc_clk);
    endtask

    task automatic load(input int si, input int sq);
        bus.set_stb = 1'b1;
        bus.set_i   = 17'(si);
        bus.set_q   = 17'(sq);
        tick(1);
        bus.set_stb = 1'b0;
    endtask

    task automatic wait_state(input int s, input int lim);
        for (int i = 0; i < lim; i++) begin
            tick(1);
            if (int'(state) == s) break;
        end
        chk("wait_state", int'(state), s);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_drive_i"}, int'(bus.drive_i), 0);
        chk({nm, "_drive_q"}, int'(bus.drive_q), 0);
        chk({nm, "_state"}, int'(state), 0);
        chk({nm, "_at"}, int'(at_target), 1);
        chk({nm, "_tripped"}, int'(tripped), 0);
        chk({nm, "_div"}, int'(bus.div_state), 0);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; trip = 1'b0;
        trip_clear = 1'b0; div_sync = 1'b0;
        bus.set_stb = 1'b0; bus.set_i = '0;
        bus.set_q = '0; bus.step = '0;
        tick(2);
        chk_reset("rst");
        rst_n = 1'b1;

        for (int k = 1; k <= 4; k++) begin
            tick(1);
            chk("div_run", int'(bus.div_state), k % 4);
        end
        tick(2);
        chk("div_pre", int'(bus.div_state), 2);
        div_sync = 1'b1;
        tick(1);
        chk("div_sync0", int'(bus.div_state), 0);
        div_sync = 1'b0;
        tick(1);
        chk("div_sync1", int'(bus.div_state), 1);

        bus.step = 12'd100;
        load(1000, -500);
        enable = 1'b1;
        tick(1);
        chk("ramp_st", int'(state), 1);
        chk("ramp_d0", int'(bus.drive_i), 0);
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            chk("ramp_i", int'(bus.drive_i), 100 * k);
            chk("ramp_q", int'(bus.drive_q),
                k >= 5 ? -500 : -100 * k);
            if (k == 9) chk("ramp_at9", int'(at_target), 0);
        end
        chk("on_st", int'(state), 2);
        chk("on_at", int'(at_target), 1);

        enable = 1'b0;
        tick(1);
        chk("down_st", int'(state), 3);
        chk("down_i0", int'(bus.drive_i), 1000);
        tick(5);
        chk("down_i5", int'(bus.drive_i), 500);
        enable = 1'b1;
        tick(1);
        chk("rev_i", int'(bus.drive_i), 400);
        chk("rev_st", int'(state), 1);
        tick(1);
        chk("rev_up_i", int'(bus.drive_i), 500);
        chk("rev_up_q", int'(bus.drive_q), -100);
        wait_state(2, 20);
        enable = 1'b0;
        tick(11);
        chk("idle_st", int'(state), 0);
        chk("idle_i", int'(bus.drive_i), 0);
        chk("idle_at", int'(at_target), 1);

        bus.step = 12'd4095;
        load(65535, 0);
        enable = 1'b1;
        wait_state(2, 40);
        chk("big_top", int'(bus.drive_i), 65535);
        load(-65536, 0);
        chk("big_s0", int'(bus.drive_i), 65535);
        chk("big_s0_at", int'(at_target), 0);
        tick(1);
        chk("big_s1", int'(bus.drive_i), 61440);
        tick(31);
        chk("big_s32", int'(bus.drive_i), -65505);
        tick(1);
        chk("big_s33", int'(bus.drive_i), -65536);
        chk("big_at", int'(at_target), 1);
        chk("big_st", int'(state), 2);
        enable = 1'b0;
        wait_state(0, 40);

        bus.step = 12'd100;
        load(1000, 0);
        enable = 1'b1;
        tick(1);
        chk("trp_ramp", int'(state), 1);
        tick(3);
        chk("trp_pre", int'(bus.drive_i), 300);
        trip = 1'b1;
        tick(1);
        chk("trp_st", int'(state), 4);
        chk("trp_i", int'(bus.drive_i), 0);
        chk("trp_flag", int'(tripped), 1);
        chk("trp_at", int'(at_target), 0);
        enable = 1'b0;
        trip_clear = 1'b1;
        tick(1);
        trip_clear = 1'b0;
        chk("clr_held", int'(state), 4);
        trip = 1'b0;
        enable = 1'b1;
        trip_clear = 1'b1;
        tick(1);
        trip_clear = 1'b0;
        chk("clr_en", int'(state), 4);
        chk("clr_en_flag", int'(tripped), 1);
        enable = 1'b0;
        trip_clear = 1'b1;
        tick(1);
        trip_clear = 1'b0;
        chk("clr_st", int'(state), 0);
        chk("clr_flag", int'(tripped), 0);
        chk("clr_at", int'(at_target), 1);

        enable = 1'b1;
        tick(1);
        chk("frz_ramp", int'(state), 1);
        tick(2);
        chk("frz_pre", int'(bus.drive_i), 200);
        bus.step = 12'd0;
        tick(20);
        chk("frz_i", int'(bus.drive_i), 200);
        chk("frz_st", int'(state), 1);
        bus.step = 12'd50;
        tick(1);
        chk("frz_resume", int'(bus.drive_i), 250);

        tick(2);
        #2 rst_n = 1'b0;
        #1 chk_reset("arst");
        tick(2);
        #2 rst_n = 1'b1;
        tick(1);
        chk("arst_st", int'(state), 1);
        chk("arst_div", int'(bus.div_state), 1);
        enable = 1'b0;
        wait_state(0, 10);
        tick(3);

        $display("test done: total=%0d bad=%0d",
                 total, bad);
        $finish;
    end

endmodule
